// File: rtl/tdm_demux.sv
// tdm_demux: receive end of a time-division multiplexed link.
//
// Tracks the slot the sender used for each valid word, collects the words of
// one frame in a shadow buffer and presents the whole frame on y together
// with a one-cycle frame_valid strobe. Framing loss (early or missing
// start-of-frame) is flagged with a one-cycle sync_err pulse and recovered
// from automatically.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   din          multiplexed data word
//   din_valid    din is valid this cycle; the slot only advances when high
//   sof          start of frame, qualified by din_valid, marks the slot-0 word
//   y            demultiplexed frame, channel k at y[k*WIDTH +: WIDTH]
//   frame_valid  one-cycle pulse: y was loaded with a complete frame
//   sel          slot index expected for the next valid word
//   locked       framer is in the LOCKED state
//   sync_err     one-cycle pulse on a framing violation
//
// state  | meaning
// HUNT   | waiting for a valid sof word; other words are dropped silently
// LOCKED | tracking slots; y reloads each time the last slot arrives

module tdm_demux #(
    parameter int WIDTH = 1,
    parameter int NCH   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         din,
    input  logic                     din_valid,
    input  logic                     sof,
    output logic [NCH*WIDTH-1:0]     y,
    output logic                     frame_valid,
    output logic [$clog2(NCH)-1:0]   sel,
    output logic                     locked,
    output logic                     sync_err
);

    localparam int SW = $clog2(NCH);
    localparam logic [SW-1:0] SEL_ZERO = '0;
    localparam logic [SW-1:0] SEL_ONE  = SW'(1);
    localparam logic [SW-1:0] SEL_LAST = SW'(NCH - 1);

    localparam logic [0:0] HUNT   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0] state;

    // Holds slots 0..NCH-2; the last slot goes straight from din into y so a
    // frame is published on the same edge that samples its final word.
    logic [(NCH-1)*WIDTH-1:0] shadow;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= HUNT;
            sel         <= SEL_ZERO;
            shadow      <= '0;
            y           <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            if (din_valid) begin
                if (state == HUNT) begin
                    if (sof) begin
                        shadow[WIDTH-1:0] <= din;
                        sel               <= SEL_ONE;
                        state             <= LOCKED;
                    end
                end else if (sof && (sel != SEL_ZERO)) begin
                    // Early frame: drop the partial frame and restart at slot 0.
                    // The later slice assignment overrides the clear for slot 0.
                    sync_err          <= 1'b1;
                    shadow            <= '0;
                    shadow[WIDTH-1:0] <= din;
                    sel               <= SEL_ONE;
                end else if (!sof && (sel == SEL_ZERO)) begin
                    // Missing marker: lose lock, discard the word.
                    sync_err <= 1'b1;
                    sel      <= SEL_ZERO;
                    state    <= HUNT;
                end else if (sel != SEL_LAST) begin
                    for (int k = 0; k < NCH - 1; k++) begin
                        if (sel == SW'(k)) begin
                            shadow[k*WIDTH +: WIDTH] <= din;
                        end
                    end
                    sel <= sel + SEL_ONE;
                end else begin
                    y           <= {din, shadow};
                    frame_valid <= 1'b1;
                    sel         <= SEL_ZERO;
                end
            end
        end
    end

    assign locked = (state == LOCKED);

endmodule
